// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: result selects, load types,
// the long-latency FIFO entry and the load byte/half extraction helper.
package wb_pkg;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_entry_t;

    // Picks the addressed byte/half out of a little-endian word and
    // sign- or zero-extends it; unknown load types return the whole word.
    function automatic logic [31:0] load_extend(
        input logic [2:0]  ld_type,
        input logic [1:0]  addr_lo,
        input logic [31:0] mem
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr_lo)
            2'd0:    b = mem[7:0];
            2'd1:    b = mem[15:8];
            2'd2:    b = mem[23:16];
            default: b = mem[31:24];
        endcase
        h = addr_lo[1] ? mem[31:16] : mem[15:0];
        case (ld_type)
            LD_LB:   r = {{24{b[7]}}, b};
            LD_LBU:  r = {24'd0, b};
            LD_LH:   r = {{16{h[15]}}, h};
            LD_LHU:  r = {16'd0, h};
            default: r = mem;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering long-latency results until a write-back slot is free.
// Ports: clk/rst (sync, active-high), push/pop strobes, din/dout entries,
// full/empty flags and current occupancy count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  ll_entry_t     din,
    output ll_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    ll_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;

    assign dout  = r_mem[r_rd];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: merges main-pipe results with buffered mul/div results
// onto the register-file write port, with load extraction and a starvation
// guard that stalls the main pipe for one cycle when the FIFO head waits too
// long.
// Ports: CLK/RST (sync, active-high); m_* main-pipe result; stall upstream
// hold; ll_* long-latency handshake; rwd/wb_data registered write port.
module wb_writer
    import wb_pkg::*;
#(
    parameter int LL_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        m_valid,
    input  logic [4:0]  m_rd,
    input  logic [1:0]  m_sel,
    input  logic [2:0]  m_ld_type,
    input  logic [1:0]  m_addr_lo,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mem,
    input  logic [31:0] m_link,
    output logic        stall,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    output logic [4:0]  rwd,
    output logic [31:0] wb_data
);

    localparam int CW  = $clog2(LL_DEPTH) + 1;
    localparam int AGW = $clog2(MAX_WAIT + 1);

    logic [4:0]     r_rwd;
    logic [31:0]    r_wb_data;
    logic           r_stall;
    logic [AGW-1:0] r_age;

    logic           w_main;
    logic           w_pop;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [31:0]    w_main_data;
    ll_entry_t      w_din;
    ll_entry_t      w_head;

    assign rwd     = r_rwd;
    assign wb_data = r_wb_data;
    assign stall   = r_stall;

    // No pop-and-push bypass: a full FIFO refuses even while it pops.
    assign ll_ready = !RST && (w_count < CW'(LL_DEPTH));

    always_comb begin
        w_main = !r_stall && m_valid && (m_rd != 5'd0);
        w_pop  = !w_main && !w_empty;
        // rd==0 transfers complete the handshake but are dropped.
        w_push = ll_valid && ll_ready && (ll_rd != 5'd0);
        w_din  = '{rd: ll_rd, data: ll_data};
        case (m_sel)
            SEL_LOAD: w_main_data = load_extend(m_ld_type, m_addr_lo, m_mem);
            SEL_LINK: w_main_data = m_link;
            default:  w_main_data = m_alu;
        endcase
    end

    wb_fifo #(
        .DEPTH (LL_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rwd     <= '0;
            r_wb_data <= '0;
            r_stall   <= 1'b0;
            r_age     <= '0;
        end else begin
            if (w_main) begin
                r_rwd     <= m_rd;
                r_wb_data <= w_main_data;
            end else if (w_pop) begin
                r_rwd     <= w_head.rd;
                r_wb_data <= w_head.data;
            end else begin
                r_rwd     <= '0;
                r_wb_data <= '0;
            end

            if (w_pop || w_empty) begin
                r_age <= '0;
            end else if (r_age < AGW'(MAX_WAIT)) begin
                r_age <= r_age + 1'b1;
            end

            // A raised stall forces a pop next edge, which clears it again.
            r_stall <= w_full && (r_age >= AGW'(MAX_WAIT - 1)) && !w_pop;
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: a vector table for main-pipe data paths and
// hand-written sequences for FIFO, starvation stall and reset behaviour.
module tb_wb_writer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_ld_type;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_alu;
    logic [31:0] m_mem;
    logic [31:0] m_link;
    logic        stall;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic [4:0]  rwd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    wb_writer #(
        .LL_DEPTH (2),
        .MAX_WAIT (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .m_valid   (m_valid),
        .m_rd      (m_rd),
        .m_sel     (m_sel),
        .m_ld_type (m_ld_type),
        .m_addr_lo (m_addr_lo),
        .m_alu     (m_alu),
        .m_mem     (m_mem),
        .m_link    (m_link),
        .stall     (stall),
        .ll_valid  (ll_valid),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .ll_ready  (ll_ready),
        .rwd       (rwd),
        .wb_data   (wb_data)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  ld;
        logic [1:0]  alo;
        logic [31:0] alu;
        logic [31:0] link;
        logic [4:0]  e_rwd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid   = 1'b0;
        m_rd      = '0;
        m_sel     = '0;
        m_ld_type = '0;
        m_addr_lo = '0;
        m_alu     = '0;
        m_link    = '0;
        ll_valid  = 1'b0;
        ll_rd     = '0;
        ll_data   = '0;
    endtask

    task automatic main_alu(input logic [4:0] rd, input logic [31:0] v);
        m_valid = 1'b1;
        m_rd    = rd;
        m_sel   = 2'd0;
        m_alu   = v;
    endtask

    task automatic ll_offer(input logic [4:0] rd, input logic [31:0] d);
        ll_valid = 1'b1;
        ll_rd    = rd;
        ll_data  = d;
    endtask

    task automatic check_wr(input string name, input logic [4:0] er,
                            input logic [31:0] ed);
        check({name, ".rwd"}, 32'(rwd), 32'(er));
        check({name, ".data"}, wb_data, ed);
    endtask

    initial begin
        m_mem = 32'h80F1_7F02;
        vecs[0]  = '{"alu",    1, 5,  0, 0, 0, 32'h1234, 0, 5,  32'h0000_1234};
        vecs[1]  = '{"idle",   0, 5,  0, 0, 0, 32'h1234, 0, 0,  32'h0};
        vecs[2]  = '{"lb3",    1, 6,  1, 0, 3, 0, 0, 6,  32'hFFFF_FF80};
        vecs[3]  = '{"lbu1",   1, 7,  1, 1, 1, 0, 0, 7,  32'h0000_007F};
        vecs[4]  = '{"lh2",    1, 8,  1, 2, 2, 0, 0, 8,  32'hFFFF_80F1};
        vecs[5]  = '{"lw",     1, 9,  1, 4, 1, 0, 0, 9,  32'h80F1_7F02};
        vecs[6]  = '{"lb2",    1, 10, 1, 0, 2, 0, 0, 10, 32'hFFFF_FFF1};
        vecs[7]  = '{"lbu3",   1, 11, 1, 1, 3, 0, 0, 11, 32'h0000_0080};
        vecs[8]  = '{"lb1",    1, 12, 1, 0, 1, 0, 0, 12, 32'h0000_007F};
        vecs[9]  = '{"lhu2",   1, 13, 1, 3, 2, 0, 0, 13, 32'h0000_80F1};
        vecs[10] = '{"lh0",    1, 14, 1, 2, 0, 0, 0, 14, 32'h0000_7F02};
        vecs[11] = '{"lh3",    1, 15, 1, 2, 3, 0, 0, 15, 32'hFFFF_80F1};
        vecs[12] = '{"ld6",    1, 16, 1, 6, 1, 0, 0, 16, 32'h80F1_7F02};
        vecs[13] = '{"link",   1, 1,  2, 0, 0, 32'h5, 32'h1008, 1, 32'h0000_1008};
        vecs[14] = '{"sel3",   1, 2,  3, 0, 0, 32'hCAFE, 32'h1, 2, 32'h0000_CAFE};
        vecs[15] = '{"rd0",    1, 0,  0, 0, 0, 32'hBEEF, 0, 0, 32'h0};

        idle_inputs();
        RST = 1'b1;
        step();
        step();
        check("rst.rwd", 32'(rwd), 32'd0);
        check("rst.data", wb_data, 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.ready", 32'(ll_ready), 32'd0);
        RST = 1'b0;
        #1;
        check("post_rst.ready", 32'(ll_ready), 32'd1);

        foreach (vecs[i]) begin
            m_valid   = vecs[i].valid;
            m_rd      = vecs[i].rd;
            m_sel     = vecs[i].sel;
            m_ld_type = vecs[i].ld;
            m_addr_lo = vecs[i].alo;
            m_alu     = vecs[i].alu;
            m_link    = vecs[i].link;
            step();
            check_wr(vecs[i].name, vecs[i].e_rwd, vecs[i].e_data);
        end
        idle_inputs();
        step();
        check("drain0", 32'(rwd), 32'd0);

        // Idle main pipe: a pushed entry is written one edge later.
        ll_offer(7, 32'hAA);
        check("ll7.ready", 32'(ll_ready), 32'd1);
        step();
        idle_inputs();
        check("ll7.push_cycle", 32'(rwd), 32'd0);
        step();
        check_wr("ll7.issue", 7, 32'hAA);
        ll_offer(0, 32'h55);
        check("ll0.ready", 32'(ll_ready), 32'd1);
        step();
        idle_inputs();
        check("ll0.w1", 32'(rwd), 32'd0);
        step();
        check("ll0.w2", 32'(rwd), 32'd0);

        // Main pipe busy: FIFO fills, then the starvation stall fires.
        main_alu(10, 32'h100);
        ll_offer(20, 32'hD0);
        step();
        check_wr("busy.m10", 10, 32'h100);
        main_alu(11, 32'h101);
        ll_offer(21, 32'hD1);
        check("busy.ready1", 32'(ll_ready), 32'd1);
        step();
        check_wr("busy.m11", 11, 32'h101);
        main_alu(12, 32'h102);
        ll_offer(22, 32'hD2);
        check("busy.full_ready", 32'(ll_ready), 32'd0);
        step();
        check_wr("busy.m12", 12, 32'h102);
        main_alu(13, 32'h103);
        step();
        check_wr("busy.m13", 13, 32'h103);
        check("busy.nostall", 32'(stall), 32'd0);
        main_alu(14, 32'h104);
        step();
        check_wr("busy.m14", 14, 32'h104);
        check("busy.stall", 32'(stall), 32'd1);
        check("busy.stall_ready", 32'(ll_ready), 32'd0);
        main_alu(15, 32'h105);
        step();
        check_wr("busy.head", 20, 32'hD0);
        check("busy.stall_clr", 32'(stall), 32'd0);
        check("busy.ready_again", 32'(ll_ready), 32'd1);
        step();
        ll_valid = 1'b0;
        check_wr("busy.m15", 15, 32'h105);
        main_alu(16, 32'h106);
        step();
        check_wr("busy.m16", 16, 32'h106);
        check("busy.stall2", 32'(stall), 32'd0);
        idle_inputs();
        step();
        check_wr("busy.ll21", 21, 32'hD1);
        step();
        check_wr("busy.ll22", 22, 32'hD2);
        step();
        check("busy.empty", 32'(rwd), 32'd0);

        // Simultaneous main write and ll push: main first, ll next.
        main_alu(3, 32'h33);
        ll_offer(4, 32'h44);
        step();
        idle_inputs();
        check_wr("sim.m3", 3, 32'h33);
        step();
        check_wr("sim.ll4", 4, 32'h44);
        step();
        check("sim.idle", 32'(rwd), 32'd0);

        // Reset with two buffered entries drops them.
        main_alu(1, 32'h11);
        ll_offer(25, 32'hE5);
        step();
        main_alu(2, 32'h22);
        ll_offer(26, 32'hE6);
        step();
        check_wr("rst6.m2", 2, 32'h22);
        idle_inputs();
        RST = 1'b1;
        #1;
        check("rst6.ready", 32'(ll_ready), 32'd0);
        step();
        check("rst6.rwd", 32'(rwd), 32'd0);
        step();
        check("rst6.rwd2", 32'(rwd), 32'd0);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst6.after%0d", k), 32'(rwd), 32'd0);
        end
        check("rst6.ready_after", 32'(ll_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
